pool_scheduler: RTL and testbench
=================================

POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one pooling engine (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum RUN cycles before abort (>=2).
REQ-003 SHALL have parameter CNT_W, default 11, timeout counter width (2**CNT_W > TIMEOUT_CYCLES).
REQ-004 SHALL have parameter SEL_W, default 3, width of sel (2**SEL_W >= NUM_REQ).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 req  input  NUM_REQ  level request per requester, held until done or abort.
REQ-008 grant  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-009 sel  output  SEL_W  binary index of granted requester, drives input/output muxes.
REQ-010 done  output  NUM_REQ  one-cycle pulse on bit sel when the engine reports result valid.
REQ-011 err  output  1  one-cycle pulse on timeout.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 eng_rst_n  output  1  engine reset, active low, pulsed to clear engine index counters per job.
REQ-014 eng_clken  output  1  engine clock enable.
REQ-015 eng_valid  input  1  engine result-valid flag.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, RUN, HOLD; all outputs registered.
REQ-017 IDLE with req!=0: SHALL pick winner round-robin, searching from last_idx+1 upward with wrap to 0, then go to CLR, setting grant one-hot, sel=winner, eng_rst_n=0.
REQ-018 IDLE with req==0: SHALL stay in IDLE, grant=0, eng_clken=0, eng_rst_n=1.
REQ-019 CLR (exactly one cycle): SHALL set eng_rst_n=1, eng_clken=1, cnt=0, go to RUN.
REQ-020 RUN: SHALL increment cnt each cycle while eng_clken=1.
REQ-021 RUN with eng_valid=1: SHALL set done[sel]=1 for one cycle, eng_clken=0, go to HOLD.
REQ-022 RUN with cnt==TIMEOUT_CYCLES-1 and eng_valid=0: SHALL pulse err, set eng_clken=0, grant=0, last_idx=sel, go to IDLE; no done.
REQ-023 eng_valid and timeout in the same cycle: SHALL take the valid path only (done, no err).
REQ-024 RUN with req[sel]=0 (abort): SHALL set eng_clken=0, grant=0, last_idx=sel, go to IDLE; no done, no err; abort outranks eng_valid in the same cycle.
REQ-025 HOLD: SHALL keep grant and sel stable (requester captures engine output) until req[sel]=0, then set grant=0, last_idx=sel, go to IDLE.
REQ-026 Requests of non-granted requesters SHALL be ignored until IDLE; no preemption.
REQ-027 Minimum turnaround SHALL be one IDLE cycle between jobs (HOLD/abort -> IDLE -> CLR).
REQ-028 busy SHALL equal (state != IDLE) registered with the state.
REQ-029 req bits >= NUM_REQ do not exist; sel SHALL never exceed NUM_REQ-1.

Reset
REQ-030 On rst_n=0 at a clock edge: state=IDLE, grant=0, sel=0, done=0, err=0, busy=0, eng_clken=0, eng_rst_n=0, cnt=0, last_idx=NUM_REQ-1 (so requester 0 wins first).
REQ-031 First cycle after reset release in IDLE SHALL drive eng_rst_n=1.
REQ-032 Reset asserted mid-job SHALL abort without done/err pulse and drop grant in the same edge.

Verification (NUM_REQ=2, TIMEOUT_CYCLES=16)
REQ-033 req=01 at cycle 0 -> grant=01, sel=0, eng_rst_n=0 at cycle 1; eng_clken=1 from cycle 2; eng_valid at cycle 9 -> done=01 at cycle 10, eng_clken=0; req drop at cycle 12 -> grant=00 at cycle 13.
REQ-034 req=11 after reset -> requester 0 served first; after its release requester 1 granted next; with both re-requesting, grants alternate 0,1,0,1.
REQ-035 req=10, eng_valid never asserted -> err pulse exactly once after 16 RUN cycles, grant=00, next IDLE with req=11 grants requester 0.
REQ-036 eng_valid coincident with cnt==15 -> done[sel]=1, err stays 0.
REQ-037 req[sel] dropped during RUN -> eng_clken=0 and grant=00 next edge, no done/err; concurrent eng_valid ignored.
REQ-038 rst_n=0 for one cycle mid-RUN -> all outputs at reset values next edge, eng_rst_n=0, no pulses; eng_rst_n=1 one cycle after release.

Source files
------------

// File: rtl/pool_scheduler.sv
// Round-robin arbiter that time-shares one pooling engine between NUM_REQ
// requesters, sequencing engine reset, clock enable, completion and timeout.
module pool_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11,
  parameter int SEL_W          = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               busy,
  output logic               eng_rst_n,
  output logic               eng_clken,
  input  logic               eng_valid
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   last_idx;
  int unsigned        last_int;
  logic [SEL_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_vld;
  logic               req_hit;

  assign last_int = 32'(last_idx);
  // grant is one-hot at sel while a job is active, so this is req[sel]
  assign req_hit  = |(req & grant);

  // Round-robin: first search above last_idx, then wrap to the low indices.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    win_vld    = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_vld && req[j] && (j > last_int)) begin
        win_vld       = 1'b1;
        win_idx       = SEL_W'(j);
        win_onehot[j] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!win_vld && req[j] && (j <= last_int)) begin
        win_vld       = 1'b1;
        win_idx       = SEL_W'(j);
        win_onehot[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      done      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      eng_clken <= 1'b0;
      eng_rst_n <= 1'b0;
      cnt       <= '0;
      last_idx  <= SEL_W'(NUM_REQ - 1);
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= CLR;
            grant     <= win_onehot;
            sel       <= win_idx;
            eng_rst_n <= 1'b0;
            busy      <= 1'b1;
          end else begin
            grant     <= '0;
            eng_clken <= 1'b0;
            eng_rst_n <= 1'b1;
            busy      <= 1'b0;
          end
        end
        CLR: begin
          eng_rst_n <= 1'b1;
          eng_clken <= 1'b1;
          cnt       <= '0;
          state     <= RUN;
        end
        RUN: begin
          // Priority: abort, then result valid, then timeout.
          if (!req_hit) begin
            eng_clken <= 1'b0;
            grant     <= '0;
            last_idx  <= sel;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (eng_valid) begin
            done      <= grant;
            eng_clken <= 1'b0;
            state     <= HOLD;
          end else if (cnt == CNT_LAST) begin
            err       <= 1'b1;
            eng_clken <= 1'b0;
            grant     <= '0;
            last_idx  <= sel;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!req_hit) begin
            grant    <= '0;
            last_idx <= sel;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_scheduler.sv
// Directed bench for pool_scheduler (NUM_REQ=2, TIMEOUT_CYCLES=16).
module tb_pool_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] grant;
  logic [2:0] sel;
  logic [1:0] done;
  logic       err;
  logic       busy;
  logic       eng_rst_n;
  logic       eng_clken;
  logic       eng_valid;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pool_scheduler #(
    .NUM_REQ(2),
    .TIMEOUT_CYCLES(16),
    .CNT_W(5),
    .SEL_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .grant(grant),
    .sel(sel),
    .done(done),
    .err(err),
    .busy(busy),
    .eng_rst_n(eng_rst_n),
    .eng_clken(eng_clken),
    .eng_valid(eng_valid)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic       vld;
    logic [1:0] grant;
    logic [2:0] sel;
    logic [1:0] done;
    logic       err;
    logic       busy;
    logic       clken;
    logic       erst;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed order: grant, sel, done, err, busy, clken, erst
  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] act;
    act = {grant, sel, done, err, busy, eng_clken, eng_rst_n};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got g=%b s=%0d d=%b e=%b b=%b ck=%b er=%b, expected g=%b s=%0d d=%b e=%b b=%b ck=%b er=%b",
                  name, act[10:9], act[8:6], act[5:4], act[3], act[2], act[1], act[0],
                  exp[10:9], exp[8:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  initial begin
    //           rst   req    vld   grant  sel   done   err   busy  clk   erst
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // idle after release
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // CLR
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1}; // RUN
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 2'b01, 1'b1, 2'b01, 3'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1}; // done
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}; // HOLD
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // release
    vecs[8]  = '{1'b1, 2'b11, 1'b0, 2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // rr -> 1
    vecs[9]  = '{1'b1, 2'b11, 1'b0, 2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 2'b01, 1'b1, 2'b00, 3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // abort beats valid
    vecs[11] = '{1'b1, 2'b11, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // rr -> 0
    vecs[12] = '{1'b1, 2'b11, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 1'b1, 2'b01, 3'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // req1 held, ignored
    vecs[15] = '{1'b1, 2'b11, 1'b0, 2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // rr -> 1
    vecs[16] = '{1'b1, 2'b11, 1'b0, 2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 2'b11, 1'b1, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // reset mid-RUN
    vecs[18] = '{1'b1, 2'b00, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 2'b11, 1'b0, 2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // 0 first again

    rst_n = 1'b0; req = '0; eng_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      rst_n     = vecs[i].rst_n;
      req       = vecs[i].req;
      eng_valid = vecs[i].vld;
      tick();
      check($sformatf("vec%0d", i),
            {vecs[i].grant, vecs[i].sel, vecs[i].done, vecs[i].err,
             vecs[i].busy, vecs[i].clken, vecs[i].erst});
    end

    // Timeout: requester 1 alone, engine never valid.
    rst_n = 1'b0; req = '0; eng_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 2'b10;
    tick();
    check("to_clr", {2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("to_run%0d", k), {2'b10, 3'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    req = 2'b11;
    tick();
    check("to_err", {2'b00, 3'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
    tick();
    check("to_next0", {2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});

    // Valid on the last timeout cycle takes the done path.
    for (int k = 0; k < 16; k++) tick();
    check("co_cnt15", {2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1});
    eng_valid = 1'b1;
    tick();
    check("co_done", {2'b01, 3'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1});
    eng_valid = 1'b0;
    tick();
    check("co_hold", {2'b01, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1});
    req = 2'b00;
    tick();
    check("co_idle", {2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
